// File: rtl/fft_power_peak.sv
// FFT bin power stage: forwards re^2+im^2 with the bin index and reports the strongest bin
// of a search window once per frame.
module fft_power_peak #(
    parameter int unsigned FFT_LEN      = 256,
    parameter int unsigned BIN_W        = $clog2(FFT_LEN),
    parameter int unsigned PEAK_MIN_BIN = 1,
    parameter int unsigned PEAK_MAX_BIN = FFT_LEN / 2 - 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic [BIN_W-1:0] m_axis_tuser,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             peak_valid,
    output logic [BIN_W-1:0] peak_bin,
    output logic [31:0]      peak_power,
    output logic             frame_err
);
    localparam logic [BIN_W-1:0] LastBin = BIN_W'(FFT_LEN - 1);
    localparam logic [BIN_W-1:0] MinBin  = BIN_W'(PEAK_MIN_BIN);
    localparam logic [BIN_W-1:0] MaxBin  = BIN_W'(PEAK_MAX_BIN);

    logic               w_en, w_accept, w_out_hs, w_elig, w_take, w_last_bin;
    logic signed [31:0] w_re, w_im, w_re_sq, w_im_sq;

    logic               r_s1_valid, r_s1_last;
    logic [31:0]        r_s1_re_sq, r_s1_im_sq;
    logic [BIN_W-1:0]   r_s1_bin;
    logic               r_s2_valid, r_s2_last;
    logic [31:0]        r_s2_power;
    logic [BIN_W-1:0]   r_s2_bin;
    logic [BIN_W-1:0]   r_bin;
    logic               r_frame_err;
    logic               r_max_loaded;
    logic [BIN_W-1:0]   r_max_bin;
    logic [31:0]        r_max_power;
    logic               r_peak_valid;
    logic [BIN_W-1:0]   r_peak_bin;
    logic [31:0]        r_peak_power;

    always_comb begin
        w_en       = !r_s2_valid || m_axis_tready;
        w_accept   = s_axis_tvalid && w_en;
        w_out_hs   = r_s2_valid && m_axis_tready;
        w_last_bin = (r_bin == LastBin);
        w_re       = {{16{s_axis_tdata[15]}}, s_axis_tdata[15:0]};
        w_im       = {{16{s_axis_tdata[31]}}, s_axis_tdata[31:16]};
        // Exact in 32 bits: the largest product is (-32768)^2 = 2^30.
        w_re_sq    = w_re * w_re;
        w_im_sq    = w_im * w_im;
        w_elig     = (r_s2_bin >= MinBin) && (r_s2_bin <= MaxBin);
        w_take     = w_elig && (!r_max_loaded || (r_s2_power > r_max_power));
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_re_sq <= '0;
            r_s1_im_sq <= '0;
            r_s1_bin   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_power <= '0;
            r_s2_bin   <= '0;
        end else if (w_en) begin
            r_s1_valid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                r_s1_re_sq <= w_re_sq;
                r_s1_im_sq <= w_im_sq;
                r_s1_bin   <= r_bin;
                r_s1_last  <= s_axis_tlast;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_power <= r_s1_re_sq + r_s1_im_sq;
                r_s2_bin   <= r_s1_bin;
                r_s2_last  <= r_s1_last;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_bin       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_accept && (s_axis_tlast != w_last_bin);
            if (w_accept) begin
                r_bin <= (s_axis_tlast || w_last_bin) ? '0 : r_bin + 1'b1;
            end
        end
    end

    // Frame close folds in the closing beat itself, then clears for the next frame.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_max_loaded <= 1'b0;
            r_max_bin    <= '0;
            r_max_power  <= '0;
            r_peak_valid <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_power <= '0;
        end else begin
            r_peak_valid <= 1'b0;
            if (w_out_hs && r_s2_last) begin
                r_peak_valid <= 1'b1;
                r_peak_bin   <= w_take ? r_s2_bin : r_max_bin;
                r_peak_power <= w_take ? r_s2_power : r_max_power;
                r_max_loaded <= 1'b0;
                r_max_bin    <= '0;
                r_max_power  <= '0;
            end else if (w_out_hs && w_take) begin
                r_max_loaded <= 1'b1;
                r_max_bin    <= r_s2_bin;
                r_max_power  <= r_s2_power;
            end
        end
    end

    assign s_axis_tready = w_en;
    assign m_axis_tvalid = r_s2_valid;
    assign m_axis_tdata  = r_s2_power;
    assign m_axis_tuser  = r_s2_bin;
    assign m_axis_tlast  = r_s2_last;
    assign peak_valid    = r_peak_valid;
    assign peak_bin      = r_peak_bin;
    assign peak_power    = r_peak_power;
    assign frame_err     = r_frame_err;

endmodule
